// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM encodings and MEM/WB bundle for the memory access stage.
package mem_access_stage_pkg;

    localparam int ASIZE = 32;
    localparam int DSIZE = 32;
    localparam int RSIZE = 5;

    // Kept as plain 1-bit constants so older netlists and dumps decode identically.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic [RSIZE-1:0] dst;
        logic             we;
    } mem_wb_t;

    // Address-to-data resize: zero-extends or truncates to the data width.
    function automatic logic [DSIZE-1:0] addr_to_data(input logic [ASIZE-1:0] a);
        return DSIZE'(a);
    endfunction

endpackage

// File: rtl/mem_access_stage_timer.sv
// Access watchdog: counts ACCESS cycles without ack and flags the last allowed one.
module access_timer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic ack,
    output logic expired
);

    logic [CW-1:0] cnt;

    // Expiry fires in the cycle the count reaches TIMEOUT-1; an ack in that cycle takes priority.
    assign expired = run && !ack && (cnt == CW'(TIMEOUT - 1));

    // Clear on launch and on termination so every access starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            if (ack || expired) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data memory handshake, stalls upstream while an
// access is outstanding, aborts stuck accesses, and owns the MEM/WB register.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no access outstanding; ALU results pass straight to MEM/WB
//   ST_ACCESS | dmem request held; waiting for dmem_ack or the watchdog
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] addr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             MemWriteIn,
    input  logic             MemReadIn,
    input  logic             MemToRegIn,
    input  logic             RegWriteIn,
    input  logic [RSIZE-1:0] wregIn,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [ASIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic [DSIZE-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic             stall,
    output logic [DSIZE-1:0] wb_data,
    output logic [RSIZE-1:0] wb_reg,
    output logic             wb_reg_write,
    output logic             mem_err,
    input  logic             err_clr
);

    logic [0:0] state;
    logic       memop;
    logic       start;
    logic       run;
    logic       timeout;
    logic       load_sel;
    mem_wb_t    mem_wb;

    assign memop    = MemReadIn | MemWriteIn;
    assign start    = (state == ST_IDLE) && memop;
    assign run      = (state == ST_ACCESS);
    // A combined read+write is a store, so load data is never selected for it.
    assign load_sel = MemToRegIn && !MemWriteIn;

    access_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .run     (run),
        .ack     (dmem_ack),
        .expired (timeout)
    );

    // Stall upstream from the launch cycle until the terminating cycle; forced low in reset.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            if (state == ST_IDLE) begin
                stall = memop;
            end else begin
                stall = !(dmem_ack | timeout);
            end
        end
    end

    // FSM and registered memory request; request fields hold for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (state == ST_IDLE) begin
            if (memop) begin
                state      <= ST_ACCESS;
                dmem_req   <= 1'b1;
                dmem_we    <= MemWriteIn;
                dmem_addr  <= addr;
                dmem_wdata <= wdata;
            end
        end else begin
            if (dmem_ack || timeout) begin
                state    <= ST_IDLE;
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
        end
    end

    // MEM/WB register: pass-through for ALU ops, bubble while waiting or on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb <= '0;
        end else if (state == ST_IDLE) begin
            if (memop) begin
                mem_wb.we <= 1'b0;
            end else begin
                mem_wb.data <= addr_to_data(addr);
                mem_wb.dst  <= wregIn;
                mem_wb.we   <= RegWriteIn;
            end
        end else if (dmem_ack) begin
            mem_wb.data <= load_sel ? dmem_rdata : addr_to_data(addr);
            mem_wb.dst  <= wregIn;
            mem_wb.we   <= RegWriteIn;
        end else if (timeout) begin
            mem_wb.we <= 1'b0;
        end
    end

    // Sticky abort flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_err <= 1'b0;
        end else if (run && timeout) begin
            mem_err <= 1'b1;
        end else if (err_clr) begin
            mem_err <= 1'b0;
        end
    end

    assign wb_data      = mem_wb.data;
    assign wb_reg       = mem_wb.dst;
    assign wb_reg_write = mem_wb.we;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] wdata;
    logic             MemWriteIn, MemReadIn, MemToRegIn, RegWriteIn;
    logic [RSIZE-1:0] wregIn;
    logic             dmem_req, dmem_we;
    logic [ASIZE-1:0] dmem_addr;
    logic [DSIZE-1:0] dmem_wdata;
    logic [DSIZE-1:0] dmem_rdata;
    logic             dmem_ack;
    logic             stall;
    logic [DSIZE-1:0] wb_data;
    logic [RSIZE-1:0] wb_reg;
    logic             wb_reg_write;
    logic             mem_err;
    logic             err_clr;

    int   checks = 0;
    int   errors = 0;
    logic model_err;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .MemWriteIn   (MemWriteIn),
        .MemReadIn    (MemReadIn),
        .MemToRegIn   (MemToRegIn),
        .RegWriteIn   (RegWriteIn),
        .wregIn       (wregIn),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall        (stall),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_reg_write (wb_reg_write),
        .mem_err      (mem_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        MemWriteIn = 1'b0; MemReadIn = 1'b0; MemToRegIn = 1'b0; RegWriteIn = 1'b0;
        addr = '0; wdata = '0; wregIn = '0; dmem_ack = 1'b0; dmem_rdata = '0; err_clr = 1'b0;
    endtask

    // One full memory transaction from the IDLE launch cycle to the edge after it ends.
    // ack_at: ACCESS cycle (1-based) carrying dmem_ack; 0 or >TIMEOUT means never.
    task automatic do_access(input logic st, input logic ld, input logic mtr, input logic rw,
                             input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr,
                             input int ack_at, input logic [31:0] rd, input logic clr);
        int          n_stall;
        int          exp_n;
        logic        acked;
        logic        exp_stall;
        logic [31:0] exp_data;
        MemWriteIn = st; MemReadIn = ld; MemToRegIn = mtr; RegWriteIn = rw;
        addr = a; wdata = wd; wregIn = wr; err_clr = clr;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL launch_stall: got %b expected 1", stall);
        end
        n_stall = 1;
        acked   = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== a || dmem_wdata !== wd) begin
            errors++;
            $display("FAIL launch_req: got req=%b we=%b addr=%h wdata=%h expected req=1 we=%b addr=%h wdata=%h",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, st, a, wd);
        end
        checks++;
        if (wb_reg_write !== 1'b0) begin
            errors++; $display("FAIL launch_bubble: got wb_reg_write=%b expected 0", wb_reg_write);
        end
        for (int c = 1; c <= TIMEOUT; c++) begin
            acked      = (c == ack_at);
            dmem_ack   = acked;
            dmem_rdata = acked ? rd : $urandom;
            exp_stall  = !(acked || c == TIMEOUT);
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++; $display("FAIL access_stall: cycle %0d got %b expected %b", c, stall, exp_stall);
            end
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== a || dmem_we !== st || dmem_wdata !== wd) begin
                errors++;
                $display("FAIL access_hold: cycle %0d got req=%b we=%b addr=%h expected req=1 we=%b addr=%h",
                         c, dmem_req, dmem_we, dmem_addr, st, a);
            end
            if (stall === 1'b1) n_stall++;
            @(posedge clk); #1;
            if (!exp_stall) break;
        end
        dmem_ack = 1'b0;
        err_clr  = 1'b0;
        exp_n = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
        checks++;
        if (n_stall != exp_n) begin
            errors++; $display("FAIL stall_cycles: got %0d expected %0d", n_stall, exp_n);
        end
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
            errors++; $display("FAIL release: got req=%b we=%b expected 0 0", dmem_req, dmem_we);
        end
        if (acked) begin
            exp_data = (mtr && !st) ? rd : a;
            checks++;
            if (wb_data !== exp_data || wb_reg !== wr || wb_reg_write !== rw) begin
                errors++;
                $display("FAIL ack_writeback: got data=%h reg=%0d we=%b expected data=%h reg=%0d we=%b",
                         wb_data, wb_reg, wb_reg_write, exp_data, wr, rw);
            end
            if (clr) model_err = 1'b0;
        end else begin
            checks++;
            if (wb_reg_write !== 1'b0) begin
                errors++; $display("FAIL timeout_bubble: got wb_reg_write=%b expected 0", wb_reg_write);
            end
            model_err = 1'b1;
        end
        checks++;
        if (mem_err !== model_err) begin
            errors++; $display("FAIL mem_err_after_access: got %b expected %b", mem_err, model_err);
        end
    endtask

    // One ALU (non-memory) cycle with optional error clear.
    task automatic do_alu(input logic [31:0] a, input logic [4:0] wr, input logic rw, input logic clr);
        idle_inputs();
        addr = a; wregIn = wr; RegWriteIn = rw; err_clr = clr;
        MemToRegIn = 1'($urandom); dmem_rdata = $urandom;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        if (clr) model_err = 1'b0;
        err_clr = 1'b0;
        checks++;
        if (wb_data !== a || wb_reg !== wr || wb_reg_write !== rw) begin
            errors++;
            $display("FAIL alu_writeback: got data=%h reg=%0d we=%b expected data=%h reg=%0d we=%b",
                     wb_data, wb_reg, wb_reg_write, a, wr, rw);
        end
        checks++;
        if (mem_err !== model_err || dmem_req !== 1'b0) begin
            errors++; $display("FAIL alu_state: got mem_err=%b req=%b expected %b 0", mem_err, dmem_req, model_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        MemReadIn = 1'b1; addr = 32'hFFFF_FFFF;
        model_err = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        checks++;
        if (dmem_req !== 0 || dmem_we !== 0 || dmem_addr !== 0 || dmem_wdata !== 0) begin
            errors++; $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h expected all 0",
                               dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        checks++;
        if (wb_data !== 0 || wb_reg !== 0 || wb_reg_write !== 0 || mem_err !== 0) begin
            errors++; $display("FAIL reset_wb: got data=%h reg=%0d we=%b err=%b expected all 0",
                               wb_data, wb_reg, wb_reg_write, mem_err);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        do_alu(32'h0000_1234, 5'd5, 1'b1, 1'b0);
        do_alu(32'hA5A5_0001, 5'd31, 1'b0, 1'b0);
    endtask

    task automatic test_load();
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7, 4, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_store();
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h55, 5'd3, 1, 32'h1111_2222, 1'b0);
        do_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h84, 32'h66, 5'd4, 2, 32'h3333_4444, 1'b0);
    endtask

    task automatic test_timeout();
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h0, 5'd9, 0, 32'h0, 1'b0);
        do_alu(32'h0, 5'd0, 1'b0, 1'b1);
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h204, 32'h0, 5'd10, TIMEOUT, 32'hCAFE_F00D, 1'b0);
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h208, 32'h0, 5'd11, 0, 32'h0, 1'b1);
        do_alu(32'h0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        MemReadIn = 1'b1; MemToRegIn = 1'b1; RegWriteIn = 1'b1; addr = 32'h100; wregIn = 5'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL mid_access_req: got %b expected 1", dmem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 0 || dmem_we !== 0 || dmem_addr !== 0 || wb_data !== 0 ||
            wb_reg !== 0 || wb_reg_write !== 0 || mem_err !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL mid_reset: got req=%b we=%b addr=%h wbd=%h wbr=%0d wbw=%b err=%b stall=%b expected all 0",
                     dmem_req, dmem_we, dmem_addr, wb_data, wb_reg, wb_reg_write, mem_err, stall);
        end
        model_err = 1'b0;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if (dmem_req !== 0 || wb_data !== 0 || wb_reg_write !== 0 || mem_err !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL stray_ack: got req=%b wbd=%h wbw=%b err=%b stall=%b expected all 0",
                     dmem_req, wb_data, wb_reg_write, mem_err, stall);
        end
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h0, 5'd13, 2, 32'h0BAD_CAFE, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h0, 5'd1, 1, 32'h0101_0101, 1'b0);
        do_access(1'b0, 1'b1, 1'b1, 1'b1, 32'h304, 32'h0, 5'd2, 1, 32'h0202_0202, 1'b0);
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h308, 32'h77, 5'd3, 1, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] a, wd, rd;
        logic [4:0]  wr;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom; wd = $urandom; rd = $urandom; wr = 5'($urandom);
            case (kind)
                0: do_alu(a, wr, 1'($urandom), ($urandom_range(0, 3) == 0));
                1: do_access(1'b0, 1'b1, 1'($urandom), 1'($urandom), a, wd, wr,
                             $urandom_range(1, 18), rd, ($urandom_range(0, 3) == 0));
                2: do_access(1'b1, 1'b0, 1'($urandom), 1'($urandom), a, wd, wr,
                             $urandom_range(1, 18), rd, ($urandom_range(0, 3) == 0));
                default: do_access(1'b1, 1'b1, 1'($urandom), 1'($urandom), a, wd, wr,
                                   $urandom_range(1, 18), rd, ($urandom_range(0, 3) == 0));
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
